instr_fetch_ctrl: RTL

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/ebpf_pkg.sv | 37 +++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ebpf_pkg.sv
// Shared eBPF fetch definitions: opcodes, instruction field layout and
// the fetch controller state encoding.
package ebpf_pkg;

    localparam int INSTR_W = 64;

    localparam logic [7:0] OP_LDDW = 8'h18;
    localparam logic [7:0] OP_EXIT = 8'h95;

    // Instruction word field layout
    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 8;
    localparam int DST_LSB = 8;
    localparam int DST_W   = 4;
    localparam int SRC_LSB = 12;
    localparam int SRC_W   = 4;
    localparam int OFF_LSB = 16;
    localparam int OFF_W   = 16;
    localparam int IMM_LSB = 32;
    localparam int IMM_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LDDW2 = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    function automatic logic [OPC_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_LSB +: OPC_W];
    endfunction

    function automatic logic [IMM_W-1:0] get_imm(input logic [INSTR_W-1:0] instr);
        return instr[IMM_LSB +: IMM_W];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry output buffer between the fetch controller and the decoder.
// Flush wins over push/pop; storage is cleared only by reset.
module fetch_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         do_push_s;
    logic         do_pop_s;

    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);
    assign count = cnt_q;
    assign rdata = mem_q[rd_ptr_q];

    // Qualify push/pop against occupancy
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
    end

    // Storage, pointers and occupancy counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// eBPF instruction fetch controller: streams 64-bit slots from a
// one-cycle-latency memory, merges lddw pairs, stops after exit and
// honours branch redirects.
module instr_fetch_ctrl
    import ebpf_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [63:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_instr,
    output logic [31:0]       out_imm_hi,
    output logic              out_wide,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [IMM_W-1:0]   imm_hi;
        logic               wide;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  rd_pc_q, rd_pc_d;      // address of the read in flight
    logic [ADDR_W-1:0]  lo_pc_q, lo_pc_d;      // address of lddw first slot
    logic [INSTR_W-1:0] lo_instr_q, lo_instr_d;
    logic               rvalid_q, rvalid_d;    // response arrives this cycle
    logic               exit_seen_q, exit_seen_d;

    logic               active_s, pop_s, resp_s, resp_exit_s, head_exit_s;
    logic               issue_s, push_s, flush_s;
    logic               full_s, empty_s;
    logic [1:0]         count_s;
    logic [2:0]         in_use_s;
    logic [OPC_W-1:0]   resp_op_s;
    entry_t             push_entry_s, head_entry_s;

    fetch_fifo #(.W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (push_entry_s),
        .pop   (pop_s),
        .flush (flush_s),
        .rdata (head_entry_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Response decode, handshake and read-issue decision
    always_comb begin
        active_s    = (state_q == ST_RUN) || (state_q == ST_LDDW2);
        pop_s       = !empty_s && out_ready;
        resp_op_s   = get_opcode(imem_rdata);
        resp_s      = rvalid_q && active_s && !redirect && !exit_seen_q;
        resp_exit_s = resp_s && (state_q == ST_RUN) && (resp_op_s == OP_EXIT);
        head_exit_s = (get_opcode(head_entry_s.instr) == OP_EXIT) && !head_entry_s.wide;
        in_use_s    = {1'b0, count_s} + {2'b00, rvalid_q};
        // Keep buffered + in-flight within two slots unless a pop frees one
        issue_s     = active_s && !redirect && !exit_seen_q && !resp_exit_s &&
                      (!full_s || pop_s) && ((in_use_s < 3'd2) || pop_s);
    end

    // Next-state, pc advance, lddw merge and buffer push/flush
    always_comb begin
        state_d      = state_q;
        exit_seen_d  = exit_seen_q;
        lo_instr_d   = lo_instr_q;
        lo_pc_d      = lo_pc_q;
        rvalid_d     = issue_s;
        push_s       = 1'b0;
        flush_s      = 1'b0;
        push_entry_s = '{instr: imem_rdata, imm_hi: 32'h0, wide: 1'b0, pc: rd_pc_q};
        if (issue_s) begin
            pc_d    = pc_q + ADDR_W'(1);
            rd_pc_d = pc_q;
        end else begin
            pc_d    = pc_q;
            rd_pc_d = rd_pc_q;
        end
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d     = ST_RUN;
                    pc_d        = start_pc;
                    exit_seen_d = 1'b0;
                    flush_s     = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    flush_s     = 1'b1;
                    pc_d        = redirect_pc;
                    exit_seen_d = 1'b0;
                end else if (resp_s) begin
                    if (resp_op_s == OP_LDDW) begin
                        lo_instr_d = imem_rdata;
                        lo_pc_d    = rd_pc_q;
                        state_d    = ST_LDDW2;
                    end else begin
                        push_s = 1'b1;
                        if (resp_op_s == OP_EXIT) begin
                            exit_seen_d = 1'b1;
                        end else begin
                            exit_seen_d = exit_seen_q;
                        end
                    end
                end else if (pop_s && head_exit_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LDDW2: begin
                if (redirect) begin
                    flush_s     = 1'b1;
                    pc_d        = redirect_pc;
                    exit_seen_d = 1'b0;
                    state_d     = ST_RUN;
                end else if (resp_s) begin
                    // Only the upper immediate of the second slot is meaningful
                    push_s       = 1'b1;
                    push_entry_s = '{instr: lo_instr_q, imm_hi: get_imm(imem_rdata),
                                     wide: 1'b1, pc: lo_pc_q};
                    state_d      = ST_RUN;
                end else begin
                    state_d = ST_LDDW2;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            rd_pc_q     <= '0;
            lo_pc_q     <= '0;
            lo_instr_q  <= '0;
            rvalid_q    <= 1'b0;
            exit_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rd_pc_q     <= rd_pc_d;
            lo_pc_q     <= lo_pc_d;
            lo_instr_q  <= lo_instr_d;
            rvalid_q    <= rvalid_d;
            exit_seen_q <= exit_seen_d;
        end
    end

    assign imem_en    = issue_s;
    assign imem_addr  = pc_q;
    assign out_valid  = !empty_s;
    assign out_instr  = head_entry_s.instr;
    assign out_imm_hi = head_entry_s.imm_hi;
    assign out_wide   = head_entry_s.wide;
    assign out_pc     = head_entry_s.pc;
    assign halted     = (state_q == ST_HALT);

endmodule
